// File: rtl/fixed_point_divider.sv
// fixed_point_divider: signed fixed-point restoring divider, one quotient bit per cycle,
// with saturation on overflow and divide-by-zero.
module fixed_point_divider #(
   parameter int WIDTH = 16,
   parameter int FRAC  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic             done,
   output logic             overflow,
   output logic             busy
);
   localparam int N  = WIDTH + FRAC;
   localparam int CW = N > 1 ? $clog2(N) : 1;
   localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [N-1:0]     QMAX = N'(SMAX);
   localparam logic [N-1:0]     QMIN = N'(SMIN);
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t           state, state_nx;
   logic [CW-1:0]    cnt;
   logic [N-1:0]     nq, nq_nx;
   logic [WIDTH-1:0] rem, dvs, mag_a, mag_b;
   logic [WIDTH:0]   rem_sh, diff;
   logic             neg, accept, last, zero_div, q_ovf;
   always_comb begin
      mag_a    = dividend[WIDTH-1] ? -dividend : dividend;
      mag_b    = divisor[WIDTH-1] ? -divisor : divisor;
      zero_div = divisor == '0;
      rem_sh   = {rem, nq[N-1]};
      diff     = rem_sh - {1'b0, dvs};
      nq_nx    = {nq[N-2:0], ~diff[WIDTH]};
      q_ovf    = neg ? nq_nx > QMIN : nq_nx > QMAX;
      accept   = state == IDLE && start;
      last     = state == CALC && cnt == '0;
      state_nx = accept ? (zero_div ? DONE : CALC) :
                 last ? DONE :
                 state == DONE ? IDLE : state;
      done     = state == DONE;
      busy     = state != IDLE;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else     state <= state_nx;
   // nq holds the unconsumed numerator bits above and the quotient bits shifted in below
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt      <= '0;
         nq       <= '0;
         rem      <= '0;
         dvs      <= '0;
         neg      <= 1'b0;
         quotient <= '0;
         overflow <= 1'b0;
      end else if (accept) begin
         cnt      <= CW'(N - 1);
         nq       <= N'(mag_a) << FRAC;
         rem      <= '0;
         dvs      <= mag_b;
         neg      <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
         overflow <= zero_div;
         if (zero_div) quotient <= dividend[WIDTH-1] ? SMIN : SMAX;
      end else if (state == CALC) begin
         cnt <= last ? '0 : cnt - 1'b1;
         nq  <= nq_nx;
         rem <= diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
         if (last) begin
            overflow <= q_ovf;
            quotient <= q_ovf ? (neg ? SMIN : SMAX) :
                        neg ? -nq_nx[WIDTH-1:0] : nq_nx[WIDTH-1:0];
         end
      end
   end
endmodule

// File: tb/tb_fixed_point_divider.sv
// tb_fixed_point_divider: directed checks of latency, rounding, saturation, start handling and reset.
module tb_fixed_point_divider;
   logic        clk, rst, start, done, overflow, busy;
   logic [15:0] dividend, divisor, quotient;
   int          checks = 0, errors = 0;

   fixed_point_divider #(.WIDTH(16), .FRAC(8)) dut (
      .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
      .quotient(quotient), .done(done), .overflow(overflow), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string t, input logic [31:0] o, input logic [31:0] e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", t, o, e);
      end
   endtask

   task automatic div(input string t, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] q, input logic ov, input int lat);
      int   n;
      logic bz;
      @(negedge clk);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      n  = 1;
      bz = busy;
      while (!done && n < 60) begin
         @(posedge clk);
         #1;
         n++;
         bz &= busy;
      end
      chk({t, " latency"}, n, lat);
      chk({t, " quotient"}, quotient, q);
      chk({t, " overflow"}, overflow, ov);
      chk({t, " busy"}, bz, 1);
      @(posedge clk);
      #1;
      chk({t, " done pulse"}, done, 0);
      chk({t, " idle"}, busy, 0);
      chk({t, " hold"}, quotient, q);
   endtask

   initial begin
      int pulses, dcyc;
      rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset quotient", quotient, 0);
      chk("reset done", done, 0);
      chk("reset overflow", overflow, 0);
      chk("reset busy", busy, 0);
      @(negedge clk);
      rst = 1'b0;

      div("3/1.5", 16'h0300, 16'h0180, 16'h0200, 1'b0, 25);
      div("-1/4", 16'hFF00, 16'h0400, 16'hFFC0, 1'b0, 25);
      div("1/3", 16'h0100, 16'h0300, 16'h0055, 1'b0, 25);
      div("-1/3", 16'hFF00, 16'h0300, 16'hFFAB, 1'b0, 25);
      div("1/0", 16'h0100, 16'h0000, 16'h7FFF, 1'b1, 1);
      div("-1/0", 16'hFF00, 16'h0000, 16'h8000, 1'b1, 1);
      div("pos sat", 16'h7F00, 16'h0010, 16'h7FFF, 1'b1, 25);
      div("neg sat", 16'h8100, 16'h0010, 16'h8000, 1'b1, 25);
      div("min exact", 16'h8000, 16'h0100, 16'h8000, 1'b0, 25);
      div("0/5", 16'h0000, 16'h0500, 16'h0000, 1'b0, 25);

      // start held high; operands change after capture
      @(negedge clk);
      dividend = 16'h0300; divisor = 16'h0180; start = 1'b1;
      @(posedge clk);
      #1;
      dividend = 16'h0100; divisor = 16'h0000;
      pulses = 0; dcyc = 0;
      for (int c = 1; c <= 25; c++) begin
         if (done) begin pulses++; dcyc = c; end
         @(posedge clk);
         #1;
      end
      chk("held start pulses", pulses, 1);
      chk("held start done cycle", dcyc, 25);
      chk("held start quotient", quotient, 16'h0200);
      chk("held start idle gap", busy, 0);
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("held start reaccept done", done, 1);
      chk("held start reaccept quotient", quotient, 16'h7FFF);
      chk("held start reaccept overflow", overflow, 1);
      @(posedge clk);
      #1;

      // reset mid-calculation
      @(negedge clk);
      dividend = 16'h0300; divisor = 16'h0180; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (9) begin @(posedge clk); #1; end
      chk("pre-reset busy", busy, 1);
      rst = 1'b1;
      #1;
      chk("abort quotient", quotient, 0);
      chk("abort overflow", overflow, 0);
      chk("abort busy", busy, 0);
      chk("abort done", done, 0);
      @(negedge clk);
      rst = 1'b0;
      pulses = 0;
      for (int c = 0; c < 30; c++) begin
         @(posedge clk);
         #1;
         if (done) pulses++;
      end
      chk("abort no done", pulses, 0);
      div("after reset", 16'h0300, 16'h0180, 16'h0200, 1'b0, 25);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/fixed_point_divider.md
FIXED_POINT_DIVIDER -- requirements
Module: fixed_point_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 16, the operand and quotient width in bits (signed two's complement).
REQ-002 SHALL have parameter FRAC, default 8, the number of fractional bits in the shared fixed-point format; 0 <= FRAC < WIDTH.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  request a division; sampled only in IDLE.
REQ-006 SHALL have port dividend  input  WIDTH  signed fixed-point numerator.
REQ-007 SHALL have port divisor  input  WIDTH  signed fixed-point denominator.
REQ-008 SHALL have port quotient  output  WIDTH  signed fixed-point result, registered.
REQ-009 SHALL have port done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port overflow  output  1  result invalid or saturated; a registered level.
REQ-011 SHALL have port busy  output  1  high in CALC and DONE.

Function
REQ-012 SHALL implement states IDLE, CALC and DONE.
REQ-013 In IDLE with start=1, SHALL capture dividend and divisor; operand changes after that edge SHALL have no effect.
REQ-014 On that same edge, SHALL clear overflow and SHALL go to CALC, except for divisor=0 (REQ-019).
REQ-015 SHALL divide magnitudes: |dividend| shifted left by FRAC (WIDTH+FRAC bits) by |divisor|, restoring division, one quotient bit per CALC cycle, MSB first.
REQ-016 SHALL run N = WIDTH+FRAC CALC cycles, counted by a down-counter loaded with N-1; CALC->DONE when the counter is 0.
REQ-017 Latency: with start sampled at the end of cycle 0, CALC occupies cycles 1..N and done=1 in cycle N+1 only.
REQ-018 In DONE, SHALL assert done for exactly one cycle and go to IDLE; quotient and overflow SHALL hold until the next accepted start.
REQ-019 divisor=0 at start: SHALL go directly to DONE (done in cycle 1) with overflow=1 and quotient saturated per the dividend sign (>=0 gives 2^(WIDTH-1)-1, <0 gives -2^(WIDTH-1)).
REQ-020 Result sign = dividend sign XOR divisor sign; rounding SHALL truncate toward zero; a zero magnitude SHALL give quotient 0.
REQ-021 Positive result with magnitude > 2^(WIDTH-1)-1: SHALL set overflow=1 and quotient=2^(WIDTH-1)-1.
REQ-022 Negative result with magnitude > 2^(WIDTH-1): SHALL set overflow=1 and quotient=-2^(WIDTH-1).
REQ-023 Magnitude of -2^(WIDTH-1) operands SHALL be handled exactly (unsigned WIDTH-bit magnitude).
REQ-024 start in CALC or DONE SHALL be ignored and SHALL NOT be queued.
REQ-025 overflow SHALL be valid whenever done=1; outside DONE it SHALL keep the last result's value.

Reset
REQ-026 rst=1 SHALL immediately force IDLE, quotient=0, done=0, overflow=0, busy=0 and the counter to 0, including mid-CALC.
REQ-027 After rst is deasserted, the first start sampled in IDLE SHALL begin a fresh division with no residue from the aborted one.

Verification (WIDTH=16, FRAC=8)
REQ-028 0x0300 / 0x0180 (3.0/1.5) -> done in cycle 25 only, quotient=0x0200, overflow=0, busy high in cycles 1-25.
REQ-029 0xFF00/0x0400 -> 0xFFC0; 0x0100/0x0300 -> 0x0055; 0xFF00/0x0300 -> 0xFFAB (truncation toward zero); all with overflow=0.
REQ-030 0x0100/0x0000 -> done in cycle 1, overflow=1, quotient=0x7FFF; 0xFF00/0x0000 -> quotient=0x8000.
REQ-031 0x7F00/0x0010 -> overflow=1, quotient=0x7FFF; 0x8100/0x0010 -> overflow=1, quotient=0x8000; 0x8000/0x0100 -> 0x8000, overflow=0.
REQ-032 start held high and operands changed during CALC -> a single done pulse, result from the originally captured operands; the next start is accepted only in the cycle after done.
REQ-033 rst pulsed in cycle 10 of a division -> outputs 0 at once with no done pulse; a new 0x0300/0x0180 afterwards -> 0x0200 after the full latency.
